// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the OpenMIPS pipeline controller.
// Stall hold vectors, exception codes and controller state codes.
package pipe_ctrl_pkg;

  localparam int StallBus = 6;

  localparam logic [StallBus-1:0] StallNone = 6'b000000;
  localparam logic [StallBus-1:0] StallId   = 6'b000111;
  localparam logic [StallBus-1:0] StallEx   = 6'b001111;
  localparam logic [StallBus-1:0] StallMem  = 6'b011111;

  localparam logic [31:0] ZeroWord  = 32'h00000000;
  localparam logic [31:0] ExcEret   = 32'h0000000e;
  localparam logic [31:0] ExcVector = 32'h00000020;

  typedef enum logic [1:0] {
    CtrlRun,
    CtrlStall,
    CtrlFlush
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Saturating consecutive-stall counter with a sticky timeout flag.
// The flag rises on the edge where the count reaches STALL_TIMEOUT.
module stall_watchdog #(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  input  logic clear,
  output logic stall_timeout
);

  localparam logic [15:0] Limit = 16'(STALL_TIMEOUT);

  logic [15:0] stall_cnt;
  logic [15:0] stall_cnt_nxt;

  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (clear || !stalled) begin
      stall_cnt_nxt = 16'd0;
    end else if (stall_cnt != Limit) begin
      stall_cnt_nxt = stall_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == Limit) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// OpenMIPS pipeline controller: stall priority, exception flush, watchdog.
// Define PIPE_CTRL_PERF_EN to add stall_cycles / flush_events counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter logic [31:0] EXC_VECTOR    = ExcVector
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_from_id,
  input  logic                stallreq_from_ex,
  input  logic                stallreq_from_mem,
  input  logic [31:0]         excepttype,
  input  logic [31:0]         cp0_epc,
  output logic [StallBus-1:0] stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                stall_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_events
`endif
);

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  ctrl_state_e state;
  ctrl_state_e state_nxt;
  logic [3:0]  flush_cnt;
  logic [3:0]  flush_cnt_nxt;
  logic [31:0] tgt;
  logic [31:0] tgt_nxt;
  logic [31:0] exc_pc;
  logic        any_req;

  assign any_req = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    tgt_nxt       = tgt;
    stall         = StallNone;
    flush         = 1'b0;
    new_pc        = ZeroWord;
    exc_pc        = (excepttype == ExcEret) ? cp0_epc : EXC_VECTOR;
    if (!rst) begin
      unique case (state)
        CtrlFlush: begin
          flush  = 1'b1;
          new_pc = tgt;
          if (flush_cnt <= 4'd1) begin
            state_nxt     = CtrlRun;
            flush_cnt_nxt = 4'd0;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
        default: begin
          if (excepttype != ZeroWord) begin
            flush   = 1'b1;
            new_pc  = exc_pc;
            tgt_nxt = exc_pc;
            if (FLUSH_CYCLES > 1) begin
              state_nxt     = CtrlFlush;
              flush_cnt_nxt = FlushLoad;
            end else begin
              state_nxt = CtrlRun;
            end
          end else begin
            // Requests overlap freely, so this must be a priority chain.
            if (stallreq_from_mem)     stall = StallMem;
            else if (stallreq_from_ex) stall = StallEx;
            else if (stallreq_from_id) stall = StallId;
            state_nxt = any_req ? CtrlStall : CtrlRun;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CtrlRun;
      flush_cnt <= 4'd0;
      tgt       <= ZeroWord;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      tgt       <= tgt_nxt;
    end
  end

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .stalled      (stall != StallNone),
    .clear        (flush),
    .stall_timeout(stall_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (stall != StallNone) stall_cycles <= stall_cycles + 32'd1;
      if (flush && state != CtrlFlush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int FC = 3;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        id, ex, mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .FLUSH_CYCLES (FC),
    .STALL_TIMEOUT(TO),
    .EXC_VECTOR   (32'h00000020)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (id),
    .stallreq_from_ex (ex),
    .stallreq_from_mem(mem),
    .excepttype       (exc),
    .cp0_epc          (epc),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_timeout    (stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
`endif
  );

  task automatic idle();
    id = 0; ex = 0; mem = 0; exc = 0; epc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; id = 1; ex = 1; mem = 1; exc = 0; epc = 0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_out: stall=%b flush=%b new_pc=%h, want 0/0/0",
                 stall, flush, new_pc);
      end
      tick();
      checks++;
      if (stall_timeout !== 1'b0) begin
        errors++;
        $display("FAIL reset_flag: got %b want 0", stall_timeout);
      end
    end
    rst = 0;
    #2;
    checks++;
    if (stall !== 6'b011111) begin
      errors++;
      $display("FAIL reset_release: stall=%b want 011111", stall);
    end
    idle();
    tick();
  endtask

  task automatic test_stall_priority();
    logic [2:0] req [6];
    logic [5:0] want [6];
    req  = '{3'b001, 3'b001, 3'b011, 3'b000, 3'b111, 3'b010};
    want = '{6'b000111, 6'b000111, 6'b001111, 6'b000000,
             6'b011111, 6'b001111};
    for (int i = 0; i < 6; i++) begin
      {mem, ex, id} = req[i];
      #2;
      checks++;
      if (stall !== want[i] || flush !== 1'b0) begin
        errors++;
        $display("FAIL stall_prio[%0d]: stall=%b flush=%b want %b/0",
                 i, stall, flush, want[i]);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_flush_exc();
    idle();
    exc = 32'h8; mem = 1;
    #2;
    checks++;
    if (flush !== 1'b1 || stall !== 6'b0 || new_pc !== 32'h20) begin
      errors++;
      $display("FAIL exc_accept: flush=%b stall=%b new_pc=%h want 1/0/20",
               flush, stall, new_pc);
    end
    tick();
    for (int i = 0; i < FC - 1; i++) begin
      exc = (i == 1) ? 32'h4 : 32'h0;
      mem = 1; id = 1; ex = i[0];
      #2;
      checks++;
      if (flush !== 1'b1 || stall !== 6'b0 || new_pc !== 32'h20) begin
        errors++;
        $display("FAIL exc_flush[%0d]: flush=%b stall=%b new_pc=%h want 1/0/20",
                 i, flush, stall, new_pc);
      end
      tick();
    end
    idle();
    #2;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b0) begin
      errors++;
      $display("FAIL exc_end: flush=%b stall=%b want 0/0", flush, stall);
    end
    tick();
  endtask

  task automatic test_eret();
    idle();
    exc = 32'he; epc = 32'h1234;
    #2;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h1234) begin
      errors++;
      $display("FAIL eret_accept: flush=%b new_pc=%h want 1/00001234",
               flush, new_pc);
    end
    tick();
    exc = 0; epc = 32'h5;
    for (int i = 0; i < FC - 1; i++) begin
      #2;
      checks++;
      if (flush !== 1'b1 || new_pc !== 32'h1234) begin
        errors++;
        $display("FAIL eret_hold[%0d]: flush=%b new_pc=%h want 1/00001234",
                 i, flush, new_pc);
      end
      tick();
    end
    #2;
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL eret_end: flush=%b want 0", flush);
    end
    tick();
  endtask

  task automatic test_watchdog();
    idle();
    tick();
    mem = 1;
    repeat (TO - 1) tick();
    mem = 0;
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL wdog_short: flag=%b want 0", stall_timeout);
    end
    tick();
    mem = 1;
    for (int i = 0; i < TO; i++) begin
      tick();
      checks++;
      if (stall_timeout !== (i == TO - 1)) begin
        errors++;
        $display("FAIL wdog_count[%0d]: flag=%b want %b",
                 i, stall_timeout, (i == TO - 1));
      end
    end
    mem = 0;
    repeat (3) tick();
    checks++;
    if (stall_timeout !== 1'b1 || stall !== 6'b0) begin
      errors++;
      $display("FAIL wdog_sticky: flag=%b stall=%b want 1/0",
               stall_timeout, stall);
    end
  endtask

  task automatic test_reset_flush();
    idle();
    exc = 32'h8;
    tick();
    exc = 0; rst = 1;
    #2;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b0 || new_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_flush: flush=%b stall=%b new_pc=%h want 0/0/0",
               flush, stall, new_pc);
    end
    tick();
    checks++;
    if (stall_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_flag: flag=%b want 0", stall_timeout);
    end
    rst = 0; id = 1;
    #2;
    checks++;
    if (flush !== 1'b0 || stall !== 6'b000111) begin
      errors++;
      $display("FAIL rst_run: flush=%b stall=%b want 0/000111", flush, stall);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    int          flush_left = 0;
    int          run = 0;
    bit          flag = 0;
    logic [31:0] tgt = 0;
    logic [5:0]  es;
    logic        ef;
    logic [31:0] ep;
    int          r;
    for (int i = 0; i < 400; i++) begin
      rst = (i == 0) || ($urandom_range(0, 49) == 0);
      id  = ($urandom_range(0, (i >= 200) ? 1 : 3) == 0);
      ex  = ($urandom_range(0, (i >= 200) ? 1 : 4) == 0);
      mem = ($urandom_range(0, (i >= 200) ? 1 : 5) == 0);
      r   = $urandom_range(0, 19);
      exc = (r == 0) ? 32'he : (r == 1) ? ($urandom | 32'h1) : 32'h0;
      epc = $urandom;
      es = 6'b0; ef = 0; ep = 32'h0;
      if (rst) begin
        es = 6'b0;
      end else if (flush_left > 0) begin
        ef = 1; ep = tgt;
      end else if (exc != 0) begin
        ef = 1; ep = (exc == 32'he) ? epc : 32'h20;
      end else begin
        es = mem ? 6'h1f : ex ? 6'h0f : id ? 6'h07 : 6'h00;
      end
      #2;
      checks++;
      if (stall !== es || flush !== ef || (ef && new_pc !== ep)) begin
        errors++;
        $display("FAIL rand[%0d]: stall=%b flush=%b new_pc=%h want %b/%b/%h",
                 i, stall, flush, new_pc, es, ef, ep);
      end
      if (rst) begin
        flush_left = 0; run = 0; flag = 0;
      end else begin
        if (flush_left > 0) flush_left--;
        else if (exc != 0) begin
          tgt = ep; flush_left = FC - 1;
        end
        run = (es != 0) ? ((run < TO) ? run + 1 : TO) : 0;
        if (run >= TO) flag = 1;
      end
      tick();
      checks++;
      if (stall_timeout !== flag) begin
        errors++;
        $display("FAIL rand_flag[%0d]: flag=%b want %b", i, stall_timeout, flag);
      end
    end
    rst = 0;
    idle();
    tick();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_stall_priority();
    test_flush_exc();
    test_eret();
    test_watchdog();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage OpenMIPS core. It takes stall requests from ID, EX and MEM and exception indications from MEM. It drives the per-stage hold vector and the flush signal seen by every pipeline register (if_id, id_ex, ex_mem, mem_wb), and supplies the redirect PC to the PC register. It also sequences multi-cycle flushes and watches for stalls that never release.

Parameters:
FLUSH_CYCLES, 1, cycles flush stays asserted after an exception is accepted (1..15)
STALL_TIMEOUT, 1024, consecutive stalled cycles before stall_timeout is raised (2..65535)
EXC_VECTOR, 32'h00000020, redirect PC for every exception except eret

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset (`RstEnable == 1'b1`)
stallreq_from_id  in  1  ID needs hold (load-use hazard)
stallreq_from_ex  in  1  EX needs hold (multi-cycle mul/div)
stallreq_from_mem  in  1  MEM needs hold (bus wait)
excepttype  in  32  nonzero = exception in MEM this cycle; 32'h0000000e = eret
cp0_epc  in  32  current EPC, used for eret
stall  out  6  hold vector: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
flush  out  1  clear all pipeline registers to NOP values
new_pc  out  32  redirect target, valid while flush=1
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=1 at posedge): state=RUN, flush_cnt=0, stall_cnt=0, latched PC=`ZeroWord`, stall_timeout=0.
  - Combinational outputs while rst=1: stall=0, flush=0, new_pc=`ZeroWord`.
- States: RUN, STALL, FLUSH. State is registered; stall, flush and new_pc are combinational from state and inputs.
- Exception accept: in RUN or STALL with excepttype!=0.
  - Same cycle: flush=1, stall=6'b000000, new_pc = (excepttype==32'h0000000e) ? cp0_epc : EXC_VECTOR.
  - At the next edge: the target is latched. If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1; otherwise go to RUN.
- FLUSH state:
  - flush=1, stall=0, new_pc=latched target.
  - All stall requests and excepttype are ignored.
  - flush_cnt decrements each cycle. When it reaches 1 at an edge, go to RUN.
- Stall priority, in RUN/STALL with no exception:
  - mem → stall=6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else 6'b000000
  - Exception beats all stall requests.
- RUN→STALL when any stall request is high (no exception). STALL→RUN when all requests are low.
- Watchdog:
  - stall_cnt increments each cycle stall!=0 and saturates at STALL_TIMEOUT.
  - It clears on any cycle with stall==0, and during flush.
  - When stall_cnt reaches STALL_TIMEOUT, stall_timeout sets and stays set until rst. Stalling itself is not altered.
- Reset mid-FLUSH or mid-STALL: returns to RUN the next cycle; no residual flush.
- Width: stall_cnt is 16 bits and flush_cnt is 4 bits. There is no wrap: both counters saturate.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles counts cycles with stall!=0.
  - flush_events counts accepted exceptions.
  - Both clear on rst and wrap modulo 2^32.
- Undefined: neither port nor its counters exist.

Decomposition:
- defines.v gains:
  - StallBus width (6)
  - stall encodings StallNone, StallId, StallEx, StallMem
  - ExcEret (32'h0000000e)
  - ExcVector
  - state codes CtrlRun, CtrlStall, CtrlFlush
- One natural sub-module: stall_watchdog (counter, saturate, sticky flag), instantiated once.

Test Plan:
- rst held 2 cycles with all requests high → stall=0, flush=0, new_pc=0, stall_timeout=0. Release → stall=6'b011111 the same cycle.
- stallreq_from_id=1 for 3 cycles, then stallreq_from_ex=1 overlapping 1 cycle → stall=000111, 000111, 001111, then 000000 after release.
- excepttype=32'h00000008 together with stallreq_from_mem=1, FLUSH_CYCLES=3 → flush=1 for exactly 3 cycles, stall=0 throughout, new_pc=32'h00000020 throughout. Requests asserted in cycles 2-3 are ignored.
- excepttype=32'h0000000e, cp0_epc=32'h00001234 → new_pc=32'h00001234. In FLUSH, cp0_epc changed to 32'h5 → new_pc stays 32'h00001234.
- STALL_TIMEOUT=8, stallreq_from_mem held 7 cycles then released → no flag. Then held 8 cycles → stall_timeout=1 and stays 1 after release, until rst.
- rst asserted in 2nd FLUSH cycle (FLUSH_CYCLES=4) → flush=0 on that cycle and after. The state after rst deasserts is RUN.
